// File: rtl/sm4_t_unit.sv
// SM4 round transform: tau (four S-boxes per word), then L (cipher) or L' (key
// expansion), on LANES independent 32-bit words, through a PIPE-deep elastic pipeline.
module sm4_t_unit #(
    parameter int LANES = 1,
    parameter int PIPE  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mode,
    input  logic [32*LANES-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_mode,
    output logic [32*LANES-1:0] out_data
);
    localparam int W = 32 * LANES;

    if (LANES < 1 || LANES > 4) begin : g_bad_lanes
        $error("sm4_t_unit: LANES must be in 1..4");
    end
    if (PIPE < 1 || PIPE > 2) begin : g_bad_pipe
        $error("sm4_t_unit: PIPE must be 1 or 2");
    end

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    function automatic logic [31:0] rol(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [W-1:0] tau(input logic [W-1:0] x);
        logic [W-1:0] y;
        y = '0;
        for (int i = 0; i < 4 * LANES; i++) y[8*i +: 8] = SBOX[x[8*i +: 8]];
        return y;
    endfunction

    function automatic logic [W-1:0] lin(input logic [W-1:0] x, input logic mode);
        logic [W-1:0] y;
        logic [31:0]  b;
        y = '0;
        for (int k = 0; k < LANES; k++) begin
            b = x[32*k +: 32];
            y[32*k +: 32] = mode ? (b ^ rol(b, 13) ^ rol(b, 23))
                                 : (b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24));
        end
        return y;
    endfunction

    logic [W-1:0] tau_data;
    assign tau_data = tau(in_data);

    // Handshake: a beat moves across a boundary on a rising edge where valid && ready;
    // a stage accepts when empty or when it hands its own beat on in the same cycle.
    if (PIPE == 1) begin : g_pipe1
        logic         v0, m0, load0, drain0;
        logic [W-1:0] d0;

        assign drain0   = v0 && out_ready;
        assign in_ready = !v0 || drain0;
        assign load0    = in_valid && in_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v0 <= 1'b0;
                m0 <= 1'b0;
                d0 <= '0;
            end else begin
                if (flush)       v0 <= 1'b0;
                else if (load0)  v0 <= 1'b1;
                else if (drain0) v0 <= 1'b0;
                if (load0 && !flush) begin
                    d0 <= lin(tau_data, in_mode);
                    m0 <= in_mode;
                end
            end
        end

        assign out_valid = v0;
        assign out_mode  = m0;
        assign out_data  = d0;
    end else begin : g_pipe2
        logic         v0, v1, m0, m1, load0, load1, drain1;
        logic [W-1:0] d0, d1;

        assign drain1   = v1 && out_ready;
        assign load1    = v0 && (!v1 || drain1);
        // stage 0 drains exactly when stage 1 takes its beat
        assign in_ready = !v0 || load1;
        assign load0    = in_valid && in_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v0 <= 1'b0;
                v1 <= 1'b0;
                m0 <= 1'b0;
                m1 <= 1'b0;
                d0 <= '0;
                d1 <= '0;
            end else begin
                if (flush) begin
                    v0 <= 1'b0;
                    v1 <= 1'b0;
                end else begin
                    if (load0)      v0 <= 1'b1;
                    else if (load1) v0 <= 1'b0;
                    if (load1)       v1 <= 1'b1;
                    else if (drain1) v1 <= 1'b0;
                end
                if (load0 && !flush) begin
                    d0 <= tau_data;
                    m0 <= in_mode;
                end
                if (load1 && !flush) begin
                    d1 <= lin(d0, m0);
                    m1 <= m0;
                end
            end
        end

        assign out_valid = v1;
        assign out_mode  = m1;
        assign out_data  = d1;
    end
endmodule

// File: tb/tb_sm4_t_unit.sv
// Bench for sm4_t_unit: a 4-lane PIPE=2 instance and a 2-lane PIPE=1 instance checked
// against a byte-table / rotate-list model, with scoreboard queues and directed sequences.
module tb_sm4_t_unit;
  localparam int WA = 128;
  localparam int WB = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          a_flush, a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_mode;
  logic [WA-1:0] a_in_data, a_out_data;
  logic          b_flush, b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode;
  logic [WB-1:0] b_in_data, b_out_data;

  sm4_t_unit #(.LANES(4), .PIPE(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_mode(a_out_mode), .out_data(a_out_data)
  );

  sm4_t_unit #(.LANES(2), .PIPE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_mode(b_out_mode), .out_data(b_out_data)
  );

  // ---------------- reference model ----------------
  logic [7:0] sbox_t [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };
  int sh_cipher [5] = '{0, 2, 10, 18, 24};
  int sh_key    [3] = '{0, 13, 23};

  // XOR of left-rotations of the substituted word, rotations taken from {t,t} shifted
  function automatic logic [31:0] ref_word(input logic [31:0] x, input logic m);
    logic [31:0] t, r;
    logic [63:0] dd;
    for (int b = 0; b < 4; b++) t[8*b +: 8] = sbox_t[x[8*b +: 8]];
    r = '0;
    for (int i = 0; i < (m ? 3 : 5); i++) begin
      dd = {t, t} << (m ? sh_key[i] : sh_cipher[i]);
      r = r ^ dd[63:32];
    end
    return r;
  endfunction

  function automatic logic [WA-1:0] ref_a(input logic [WA-1:0] x, input logic m);
    logic [WA-1:0] y;
    for (int k = 0; k < 4; k++) y[32*k +: 32] = ref_word(x[32*k +: 32], m);
    return y;
  endfunction

  function automatic logic [WB-1:0] ref_b(input logic [WB-1:0] x, input logic m);
    logic [WB-1:0] y;
    for (int k = 0; k < 2; k++) y[32*k +: 32] = ref_word(x[32*k +: 32], m);
    return y;
  endfunction

  // ---------------- checking ----------------
  int n_pass = 0;
  int n_total = 0;
  int a_outs = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [WA:0] exp_a_q[$];
  logic [WB:0] exp_b_q[$];
  logic        a_prev_stall = 1'b0, b_prev_stall = 1'b0;
  logic [WA:0] a_prev_beat;
  logic [WB:0] b_prev_beat;

  always @(negedge clk) begin
    logic [WA:0] e;
    if (rst_n) begin
      if (a_prev_stall && a_out_valid) chk("a_hold", {a_out_mode, a_out_data}, a_prev_beat);
      if (a_out_valid && a_out_ready) begin
        a_outs++;
        if (exp_a_q.size() == 0) chk("a_unexpected_beat", 1, 0);
        else begin
          e = exp_a_q.pop_front();
          chk("a_beat", {a_out_mode, a_out_data}, e);
        end
      end
      if (a_flush) exp_a_q.delete();
      else if (a_in_valid && a_in_ready) exp_a_q.push_back({a_in_mode, ref_a(a_in_data, a_in_mode)});
    end
    a_prev_stall = rst_n && a_out_valid && !a_out_ready;
    a_prev_beat  = {a_out_mode, a_out_data};
  end

  always @(negedge clk) begin
    logic [WB:0] e;
    if (rst_n) begin
      if (b_prev_stall && b_out_valid) chk("b_hold", {b_out_mode, b_out_data}, b_prev_beat);
      if (b_out_valid && b_out_ready) begin
        if (exp_b_q.size() == 0) chk("b_unexpected_beat", 1, 0);
        else begin
          e = exp_b_q.pop_front();
          chk("b_beat", {b_out_mode, b_out_data}, e);
        end
      end
      if (b_flush) exp_b_q.delete();
      else if (b_in_valid && b_in_ready) exp_b_q.push_back({b_in_mode, ref_b(b_in_data, b_in_mode)});
    end
    b_prev_stall = rst_n && b_out_valid && !b_out_ready;
    b_prev_beat  = {b_out_mode, b_out_data};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        mode;
    logic [31:0] din;
    logic [31:0] dout;
  } vec_t;
  vec_t vecs[8];

  task automatic run_vec_a(input vec_t v);
    a_in_valid = 1'b1; a_in_mode = v.mode; a_in_data = {4{v.din}}; a_out_ready = 1'b1;
    @(negedge clk);
    chk("vec_a_in_ready", a_in_ready, 1);
    step();
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("vec_a_not_early", a_out_valid, 0);
    step();
    @(negedge clk);
    chk("vec_a_out_valid", a_out_valid, 1);
    chk("vec_a_out_data", a_out_data, {4{v.dout}});
    chk("vec_a_out_mode", a_out_mode, v.mode);
    step();
  endtask

  task automatic run_vec_b(input vec_t v);
    b_in_valid = 1'b1; b_in_mode = v.mode; b_in_data = {2{v.din}}; b_out_ready = 1'b1;
    @(negedge clk);
    chk("vec_b_in_ready", b_in_ready, 1);
    chk("vec_b_idle", b_out_valid, 0);
    step();
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("vec_b_out_valid", b_out_valid, 1);
    chk("vec_b_out_data", b_out_data, {2{v.dout}});
    chk("vec_b_out_mode", b_out_mode, v.mode);
    step();
  endtask

  task automatic rand_stream(input int ncyc);
    logic have_a, have_b;
    have_a = 1'b0; have_b = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (!have_a && $urandom_range(0, 3) != 0) begin
        have_a = 1'b1;
        a_in_mode = 1'($urandom_range(0, 1));
        a_in_data = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!have_b && $urandom_range(0, 3) != 0) begin
        have_b = 1'b1;
        b_in_mode = 1'($urandom_range(0, 1));
        b_in_data = {$urandom, $urandom};
      end
      a_in_valid = have_a; a_out_ready = ($urandom_range(0, 3) != 0);
      b_in_valid = have_b; b_out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (a_in_valid && a_in_ready) have_a = 1'b0;
      if (b_in_valid && b_in_ready) have_b = 1'b0;
      step();
    end
    a_in_valid = 1'b0; b_in_valid = 1'b0;
  endtask

  initial begin
    int idx, outs0;
    logic acc;
    vecs[0] = '{1'b0, 32'h00000000, 32'h5B5B5B5B};
    vecs[1] = '{1'b1, 32'h00000000, 32'h67676767};
    vecs[2] = '{1'b0, 32'hFFFFFFFF, 32'h21212121};
    vecs[3] = '{1'b0, 32'hABABABAB, 32'hAEAEAEAE};
    vecs[4] = '{1'b1, 32'hFFFFFFFF, 32'h65656565};
    vecs[5] = '{1'b1, 32'hABABABAB, 32'h0B0B0B0B};
    vecs[6] = '{1'b0, 32'h01010101, 32'h42424242};
    vecs[7] = '{1'b1, 32'h01010101, 32'hCACACACA};

    a_flush = 0; a_in_valid = 0; a_in_mode = 0; a_in_data = '0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_mode = 0; b_in_data = '0; b_out_ready = 0;

    // reset state
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", a_out_valid, 0);
    chk("reset_out_data", a_out_data, 0);
    chk("reset_out_mode", a_out_mode, 0);
    chk("reset_b_out_valid", b_out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", a_in_ready, 1);
    chk("reset_b_in_ready", b_in_ready, 1);
    step();

    foreach (vecs[i]) run_vec_a(vecs[i]);
    foreach (vecs[i]) run_vec_b(vecs[i]);

    // four distinct lanes, back to back, no bubbles
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_mode = 1'b0;
    a_in_data = {32'h00000000, 32'h00000000, 32'hABABABAB, 32'hFFFFFFFF};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        chk("b2b_out_valid", a_out_valid, 1);
        chk("b2b_out_data", a_out_data, {32'h5B5B5B5B, 32'h5B5B5B5B, 32'hAEAEAEAE, 32'h21212121});
      end
      step();
      if (k == 4) a_in_valid = 1'b0;
    end

    // backpressure: 6 beats alternating mode, out_ready low for 4 cycles
    idx = 0; outs0 = a_outs; acc = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (acc) a_in_data = {$urandom, $urandom, $urandom, $urandom};
      a_out_ready = !(c >= 2 && c < 6);
      a_in_valid  = (idx < 6);
      a_in_mode   = idx[0];
      @(negedge clk);
      if (c == 4) begin
        chk("bp_in_ready_low", a_in_ready, 0);
        chk("bp_out_valid_held", a_out_valid, 1);
      end
      acc = a_in_valid && a_in_ready;
      if (acc) idx++;
      step();
    end
    a_in_valid = 1'b0;
    chk("bp_all_sent", idx, 6);
    chk("bp_all_delivered", a_outs - outs0, 6);

    // flush with two beats in flight
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_mode = 1'b1; a_in_data = {4{32'h12345678}};
    @(negedge clk); step();
    @(negedge clk); step();
    a_in_valid = 1'b0; outs0 = a_outs;
    @(negedge clk);
    chk("flush_pre_full", a_out_valid, 1);
    step();
    a_flush = 1'b1;
    @(negedge clk);
    step();
    a_flush = 1'b0; a_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_out_valid", a_out_valid, 0);
      step();
    end
    chk("flush_no_emerge", a_outs - outs0, 0);
    // a beat accepted during flush is discarded
    a_in_valid = 1'b1; a_flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", a_in_ready, 1);
    step();
    a_in_valid = 1'b0; a_flush = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("flush_discard", a_out_valid, 0);
      step();
    end
    chk("flush_discard_cnt", a_outs - outs0, 0);
    run_vec_a(vecs[2]);

    rand_stream(300);
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    repeat (4) step();

    // asynchronous reset mid-stream
    a_in_valid = 1'b1; a_in_mode = 1'b0; a_in_data = {4{32'hCAFEF00D}};
    b_in_valid = 1'b1; b_in_mode = 1'b1; b_in_data = {2{32'h0BADBEEF}};
    @(negedge clk); step();
    @(negedge clk); step();
    #1 rst_n = 1'b0;
    exp_a_q.delete(); exp_b_q.delete();
    #1;
    chk("rst_mid_out_valid", a_out_valid, 0);
    chk("rst_mid_out_data", a_out_data, 0);
    chk("rst_mid_b_out_valid", b_out_valid, 0);
    chk("rst_mid_b_out_data", b_out_data, 0);
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", a_in_ready, 1);
    chk("rst_mid_b_in_ready", b_in_ready, 1);
    chk("rst_mid_no_output", a_out_valid, 0);
    step();
    run_vec_b(vecs[0]);
    run_vec_a(vecs[0]);

    rand_stream(200);
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    repeat (5) step();
    chk("a_queue_drained", exp_a_q.size(), 0);
    chk("b_queue_drained", exp_b_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
